// File: rtl/ram_init_loader.sv
// ram_init_loader: boot-time program loader for the RAM address/data selector.
// Parses a UART byte stream (16-bit big-endian word count N, then N big-endian
// 16-bit words) and issues sequential handshaked RAM writes starting at BASE_ADDR.
// A one-byte skid register absorbs bytes that arrive while a write is pending.
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   start            pulse: begin a load (accepted only when idle)
//   rx_data/rx_valid received byte and its strobe
//   wr_ack           RAM controller accepted the pending write
//   initializing     high for the whole load (selector routes init_* to RAM)
//   init_addr/data   RAM write address/data, init_we write request held until wr_ack
//   done             one-cycle pulse at end of load
//   overrun          sticky: a byte was dropped because the skid register was full
module ram_init_loader #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              wr_ack,
    output logic              initializing,
    output logic [ADDR_W-1:0] init_addr,
    output logic [DATA_W-1:0] init_data,
    output logic              init_we,
    output logic              done,
    output logic              overrun
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned LEN_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO, S_WRITE, S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [BYTE_W-1:0]   skid_q, skid_d;
    logic                skid_vld_q, skid_vld_d;
    logic [BYTE_W-1:0]   hi_q, hi_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic                initializing_q, initializing_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                we_q, we_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;

    logic                byte_state_c;
    logic                byte_vld_c;
    logic [BYTE_W-1:0]   byte_val_c;

    // Skid byte has priority over the live receiver byte
    always_comb begin
        byte_state_c = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                       (state_q == S_DAT_HI) || (state_q == S_DAT_LO);
        byte_vld_c   = skid_vld_q | rx_valid;
        byte_val_c   = skid_vld_q ? skid_q : rx_data;
    end

    // Next-state and next-output logic
    always_comb begin
        state_d        = state_q;
        skid_d         = skid_q;
        skid_vld_d     = skid_vld_q;
        hi_d           = hi_q;
        rem_d          = rem_q;
        initializing_d = initializing_q;
        addr_d         = addr_q;
        data_d         = data_q;
        we_d           = we_q;
        done_d         = 1'b0;
        overrun_d      = overrun_q;

        // Skid: refill while draining in byte states, capture or drop during a write
        if (byte_state_c && skid_vld_q) begin
            skid_vld_d = rx_valid;
            skid_d     = rx_data;
        end else if (state_q == S_WRITE && rx_valid) begin
            if (skid_vld_q) begin
                overrun_d = 1'b1;
            end else begin
                skid_vld_d = 1'b1;
                skid_d     = rx_data;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d        = S_LEN_HI;
                    initializing_d = 1'b1;
                    overrun_d      = 1'b0;
                    addr_d         = BASE_ADDR;
                    skid_vld_d     = 1'b0;
                end
            end
            S_LEN_HI: begin
                if (byte_vld_c) begin
                    hi_d    = byte_val_c;
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (byte_vld_c) begin
                    rem_d = {hi_q, byte_val_c};
                    if ({hi_q, byte_val_c} == LEN_W'(0)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_DAT_HI;
                    end
                end
            end
            S_DAT_HI: begin
                if (byte_vld_c) begin
                    hi_d    = byte_val_c;
                    state_d = S_DAT_LO;
                end
            end
            S_DAT_LO: begin
                if (byte_vld_c) begin
                    data_d  = DATA_W'({hi_q, byte_val_c});
                    we_d    = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (wr_ack) begin
                    we_d   = 1'b0;
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_DAT_HI;
                    end
                end
            end
            S_DONE: begin
                initializing_d = 1'b0;
                skid_vld_d     = 1'b0;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            skid_q         <= '0;
            skid_vld_q     <= 1'b0;
            hi_q           <= '0;
            rem_q          <= '0;
            initializing_q <= 1'b0;
            addr_q         <= '0;
            data_q         <= '0;
            we_q           <= 1'b0;
            done_q         <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            skid_q         <= skid_d;
            skid_vld_q     <= skid_vld_d;
            hi_q           <= hi_d;
            rem_q          <= rem_d;
            initializing_q <= initializing_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            we_q           <= we_d;
            done_q         <= done_d;
            overrun_q      <= overrun_d;
        end
    end

    assign initializing = initializing_q;
    assign init_addr    = addr_q;
    assign init_data    = data_q;
    assign init_we      = we_q;
    assign done         = done_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_ram_init_loader.sv
// tb_ram_init_loader: directed bench for ram_init_loader. Two instances share all
// inputs: one with BASE_ADDR=0 and one with BASE_ADDR=2^18-1 (address wrap case).
module tb_ram_init_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        wr_ack;

    logic        a_init, b_init;
    logic [17:0] a_addr, b_addr;
    logic [15:0] a_data, b_data;
    logic        a_we, b_we;
    logic        a_done, b_done;
    logic        a_ovr, b_ovr;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ram_init_loader #(.ADDR_W(18), .DATA_W(16), .BASE_ADDR(18'h00000)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .wr_ack(wr_ack), .initializing(a_init), .init_addr(a_addr), .init_data(a_data),
        .init_we(a_we), .done(a_done), .overrun(a_ovr)
    );

    ram_init_loader #(.ADDR_W(18), .DATA_W(16), .BASE_ADDR(18'h3FFFF)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .wr_ack(wr_ack), .initializing(b_init), .init_addr(b_addr), .init_data(b_data),
        .init_we(b_we), .done(b_done), .overrun(b_ovr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All stimulus tasks begin and end on a falling edge
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic ack();
        wr_ack = 1'b1;
        @(negedge clk);
        wr_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_we(input int max_cyc);
        int i;
        i = 0;
        while (!a_we && i < max_cyc) begin
            @(negedge clk);
            i++;
        end
        if (!a_we) chk("we_timeout", 32'(a_we), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        wr_ack   = 1'b0;
        idle(2);
        chk("rst_init", 32'(a_init), 32'd0);
        chk("rst_we",   32'(a_we),   32'd0);
        chk("rst_addr", 32'(a_addr), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        rst = 1'b1;
        idle(1);

        // Reset in the middle of a pending write acts immediately
        pulse_start();
        send(8'h00); send(8'h02); send(8'h12); send(8'h34);
        chk("t1_we_before", 32'(a_we), 32'd1);
        rst = 1'b0;
        #1;
        chk("t1_we",   32'(a_we),   32'd0);
        chk("t1_init", 32'(a_init), 32'd0);
        chk("t1_addr", 32'(a_addr), 32'd0);
        chk("t1_data", 32'(a_data), 32'd0);
        chk("t1_baddr", 32'(b_addr), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        chk("t1_idle_init", 32'(a_init), 32'd0);

        // Two-word load with prompt acks (also the wrap case on instance b)
        pulse_start();
        chk("t2_init", 32'(a_init), 32'd1);
        chk("t2_addr0", 32'(a_addr), 32'h00000);
        send(8'h00); send(8'h02); send(8'h12); send(8'h34);
        chk("t2_we1",   32'(a_we),   32'd1);
        chk("t2_addr1", 32'(a_addr), 32'h00000);
        chk("t2_data1", 32'(a_data), 32'h1234);
        chk("t5_addr1", 32'(b_addr), 32'h3FFFF);
        ack();
        chk("t2_we_off", 32'(a_we), 32'd0);
        chk("t2_done_early", 32'(a_done), 32'd0);
        send(8'hAB); send(8'hCD);
        chk("t2_we2",   32'(a_we),   32'd1);
        chk("t2_addr2", 32'(a_addr), 32'h00001);
        chk("t2_data2", 32'(a_data), 32'hABCD);
        chk("t5_addr2", 32'(b_addr), 32'h00000);
        chk("t5_data2", 32'(b_data), 32'hABCD);
        ack();
        chk("t2_done", 32'(a_done), 32'd1);
        idle(1);
        chk("t2_done_off", 32'(a_done), 32'd0);
        chk("t2_init_off", 32'(a_init), 32'd0);
        chk("t2_addr_end", 32'(a_addr), 32'h00002);
        chk("t2_data_end", 32'(a_data), 32'hABCD);
        chk("t5_addr_end", 32'(b_addr), 32'h00001);

        // Zero-length load
        pulse_start();
        send(8'h00); send(8'h00);
        chk("t3_done", 32'(a_done), 32'd1);
        chk("t3_we",   32'(a_we),   32'd0);
        idle(1);
        chk("t3_done_off", 32'(a_done), 32'd0);
        chk("t3_init",     32'(a_init), 32'd0);
        chk("t3_addr",     32'(a_addr), 32'h00000);

        // One byte during a slow write is held in the skid register
        pulse_start();
        send(8'h00); send(8'h02); send(8'h11); send(8'h22);
        send(8'h33);
        idle(9);
        chk("t4_we_held", 32'(a_we),   32'd1);
        chk("t4_data1",   32'(a_data), 32'h1122);
        chk("t4_addr1",   32'(a_addr), 32'h00000);
        ack();
        send(8'h44);
        wait_we(5);
        chk("t4_data2",  32'(a_data), 32'h3344);
        chk("t4_addr2",  32'(a_addr), 32'h00001);
        chk("t4_ovr0",   32'(a_ovr),  32'd0);
        ack();
        chk("t4_done",   32'(a_done), 32'd1);
        idle(1);

        // Two bytes during a write: second is dropped, overrun sticks until start
        pulse_start();
        send(8'h00); send(8'h02); send(8'h55); send(8'h66);
        send(8'h77); send(8'h88);
        chk("t4_ovr1", 32'(a_ovr), 32'd1);
        idle(3);
        ack();
        send(8'h99);
        wait_we(5);
        chk("t4_data3", 32'(a_data), 32'h7799);
        ack();
        chk("t4_done2", 32'(a_done), 32'd1);
        idle(1);
        chk("t4_ovr_sticky", 32'(a_ovr), 32'd1);
        pulse_start();
        chk("t4_ovr_clr", 32'(a_ovr), 32'd0);
        send(8'h00); send(8'h00);
        idle(1);

        // start pulses during DAT_HI and WRITE are ignored
        pulse_start();
        send(8'h00); send(8'h02);
        pulse_start();
        chk("t6_init", 32'(a_init), 32'd1);
        chk("t6_addr0", 32'(a_addr), 32'h00000);
        send(8'h12); send(8'h34);
        pulse_start();
        chk("t6_we1",   32'(a_we),   32'd1);
        chk("t6_addr1", 32'(a_addr), 32'h00000);
        chk("t6_data1", 32'(a_data), 32'h1234);
        ack();
        send(8'h56); send(8'h78);
        chk("t6_addr2", 32'(a_addr), 32'h00001);
        chk("t6_data2", 32'(a_data), 32'h5678);
        ack();
        chk("t6_done", 32'(a_done), 32'd1);
        chk("t6_addr_end", 32'(a_addr), 32'h00002);
        idle(1);
        chk("t6_init_off", 32'(a_init), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
